// File: rtl/stream_packer_out_arb.sv
// -----------------------------------------------------------------------------
// stream_packer_out_arb
// Frame-level round-robin arbiter merging N_CH packed AXI-Stream channels onto
// one egress port. A grant is held from the first beat of a frame to its tlast,
// so frames never interleave. Each egress beat carries its source channel in
// m_tid. The egress side is a single registered slice.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   arb_en            1 = new grants allowed; 0 = finish current frame, then idle
//   ch_mask[N_CH]     per-channel enable for new grants
//   s_t*              per-channel ingress (data/keep/last/valid in, ready out)
//   m_t*              egress stream (data/keep/last/id/valid out, ready in)
//   busy              a frame is granted or the output slice holds data
//   wd_abort, wd_ch   watchdog abort pulse and sticky per-channel abort flags
//                     (only with the watchdog build)
//
// Build option: define STREAM_PACKER_ARB_WATCHDOG_EN to add a stall watchdog
// that closes a stalled frame with an empty tlast beat after WD_CYCLES cycles.
// -----------------------------------------------------------------------------
module stream_packer_out_arb #(
  parameter int unsigned N_CH       = 4,
  parameter int unsigned DWIDTH_OUT = 32,
`ifdef STREAM_PACKER_ARB_WATCHDOG_EN
  parameter int unsigned WD_CYCLES  = 256,
`endif
  localparam int unsigned IDW       = $clog2(N_CH),
  localparam int unsigned KW        = DWIDTH_OUT / 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     arb_en,
  input  logic [N_CH-1:0]          ch_mask,
  input  logic [N_CH*DWIDTH_OUT-1:0] s_tdata,
  input  logic [N_CH*KW-1:0]       s_tkeep,
  input  logic [N_CH-1:0]          s_tlast,
  input  logic [N_CH-1:0]          s_tvalid,
  output logic [N_CH-1:0]          s_tready,
  output logic [DWIDTH_OUT-1:0]    m_tdata,
  output logic [KW-1:0]            m_tkeep,
  output logic                     m_tlast,
  output logic [IDW-1:0]           m_tid,
  output logic                     m_tvalid,
  input  logic                     m_tready,
`ifdef STREAM_PACKER_ARB_WATCHDOG_EN
  output logic                     wd_abort,
  output logic [N_CH-1:0]          wd_ch,
`endif
  output logic                     busy
);

  typedef enum logic {IDLE, XFER} state_e;

  state_e                state_q, state_d;
  logic [IDW-1:0]        grant_q, grant_d;
  logic [IDW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [DWIDTH_OUT-1:0] out_data_q, out_data_d;
  logic [KW-1:0]         out_keep_q, out_keep_d;
  logic                  out_last_q, out_last_d;
  logic [IDW-1:0]        out_id_q, out_id_d;
  logic                  out_valid_q, out_valid_d;
  logic                  busy_q, busy_d;

  logic [N_CH-1:0]       req;
  logic [IDW-1:0]        pick;
  logic                  found;
  logic                  slice_ready;
  logic                  accept;
  logic                  wd_fire;
  logic [DWIDTH_OUT-1:0] sel_data;
  logic [KW-1:0]         sel_keep;
  logic                  sel_last;
  logic                  sel_valid;

`ifdef STREAM_PACKER_ARB_WATCHDOG_EN
  localparam int unsigned WDW = (WD_CYCLES > 2) ? $clog2(WD_CYCLES) : 1;
  localparam logic [WDW-1:0] WD_MAX = WDW'(WD_CYCLES - 1);

  logic [WDW-1:0]  wd_cnt_q, wd_cnt_d;
  logic            wd_abort_q, wd_abort_d;
  logic [N_CH-1:0] wd_ch_q, wd_ch_d;
`endif

  // Granted-channel mux and round-robin search starting after rr_ptr
  always_comb begin
    req       = s_tvalid & ch_mask;
    sel_data  = '0;
    sel_keep  = '0;
    sel_last  = 1'b0;
    sel_valid = 1'b0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (grant_q == IDW'(c)) begin
        sel_data  = s_tdata[c*DWIDTH_OUT +: DWIDTH_OUT];
        sel_keep  = s_tkeep[c*KW +: KW];
        sel_last  = s_tlast[c];
        sel_valid = s_tvalid[c];
      end
    end

    // Descending scan: the last hit is the closest channel after rr_ptr
    pick  = '0;
    found = 1'b0;
    for (int i = int'(N_CH); i >= 1; i--) begin
      if (req[(int'(rr_ptr_q) + i) % int'(N_CH)]) begin
        pick  = IDW'((int'(rr_ptr_q) + i) % int'(N_CH));
        found = 1'b1;
      end
    end
  end

  // Next-state, ready and output-slice logic
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_id_d    = out_id_q;
    out_valid_d = out_valid_q;
    s_tready    = '0;
    accept      = 1'b0;
    wd_fire     = 1'b0;
    slice_ready = !out_valid_q || m_tready;
`ifdef STREAM_PACKER_ARB_WATCHDOG_EN
    wd_cnt_d    = wd_cnt_q;
    wd_abort_d  = 1'b0;
    wd_ch_d     = wd_ch_q;
`endif

    case (state_q)
      IDLE: begin
        if (arb_en && found) begin
          grant_d = pick;
          state_d = XFER;
        end
      end
      XFER: begin
`ifdef STREAM_PACKER_ARB_WATCHDOG_EN
        wd_fire = (wd_cnt_q == WD_MAX) && !sel_valid && slice_ready;
`endif
        for (int unsigned c = 0; c < N_CH; c++) begin
          s_tready[c] = (grant_q == IDW'(c)) && slice_ready && !wd_fire;
        end
        accept = sel_valid && slice_ready && !wd_fire;
        // Frame ends on tlast or on a watchdog abort; both hand priority on
        if ((accept && sel_last) || wd_fire) begin
          rr_ptr_d = grant_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      out_data_d  = sel_data;
      out_keep_d  = sel_keep;
      out_last_d  = sel_last;
      out_id_d    = grant_q;
      out_valid_d = 1'b1;
    end else if (wd_fire) begin
      // Empty closing beat so downstream sees a terminated frame
      out_data_d  = '0;
      out_keep_d  = '0;
      out_last_d  = 1'b1;
      out_id_d    = grant_q;
      out_valid_d = 1'b1;
    end else if (m_tready) begin
      out_valid_d = 1'b0;
    end

`ifdef STREAM_PACKER_ARB_WATCHDOG_EN
    // Counts stalled cycles of the granted channel; saturates at WD_MAX
    if (state_q != XFER || accept || wd_fire) begin
      wd_cnt_d = '0;
    end else if (!sel_valid && wd_cnt_q != WD_MAX) begin
      wd_cnt_d = wd_cnt_q + WDW'(1);
    end
    if (wd_fire) begin
      wd_abort_d       = 1'b1;
      wd_ch_d[grant_q] = 1'b1;
    end
`endif

    busy_d = (state_d == XFER) || out_valid_d;
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      rr_ptr_q    <= IDW'(N_CH - 1);
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      out_id_q    <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef STREAM_PACKER_ARB_WATCHDOG_EN
      wd_cnt_q    <= '0;
      wd_abort_q  <= 1'b0;
      wd_ch_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      rr_ptr_q    <= rr_ptr_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_id_q    <= out_id_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
`ifdef STREAM_PACKER_ARB_WATCHDOG_EN
      wd_cnt_q    <= wd_cnt_d;
      wd_abort_q  <= wd_abort_d;
      wd_ch_q     <= wd_ch_d;
`endif
    end
  end

  assign m_tdata  = out_data_q;
  assign m_tkeep  = out_keep_q;
  assign m_tlast  = out_last_q;
  assign m_tid    = out_id_q;
  assign m_tvalid = out_valid_q;
  assign busy     = busy_q;
`ifdef STREAM_PACKER_ARB_WATCHDOG_EN
  assign wd_abort = wd_abort_q;
  assign wd_ch    = wd_ch_q;
`endif

endmodule
